interrupt_controller: RTL and testbench

INTERRUPT_CONTROLLER -- requirements
Module: interrupt_controller

---
 rtl/interrupt_controller.sv | 153 +++++++++++++++
 tb/tb_interrupt_controller.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/interrupt_controller.sv
// interrupt_controller -- four-source, fixed-priority interrupt controller
// with a single outstanding request/service handshake to the CPU.
//
// Optional build macro: INTC_OVERRUN_EN
//   defined   : per-source sticky overrun flags (ovf), cleared by ovf_clr.
//   undefined : ovf is tied to 4'b0000 and ovf_clr is ignored.
//
// Parameters
//   VEC_BASE    base address of the 4-entry vector table (2 words/entry)
// Ports
//   clock       rising-edge clock
//   reset       asynchronous active-low reset
//   src[3:0]    one-cycle event pulses (src[0] = timer tick, highest priority)
//   mask_we     load mask_in into the enable mask
//   mask_in     new mask value, 1 = source enabled
//   int_ack     CPU accepts the current request
//   eoi         CPU end-of-interrupt
//   ovf_clr     clear all overrun flags
//   int_req     registered interrupt request
//   int_addr    registered handler address, VEC_BASE + 2*id
//   in_service  a handler is active
//   pend[3:0]   pending events (status)
//   ovf[3:0]    sticky overrun flags

// One pending bit (and optional overrun flag) per source.
module intc_lane (
  input  logic clock,
  input  logic reset,
  input  logic set,
  input  logic clr,
  input  logic ovf_clr,
  output logic pend,
  output logic ovf
);

  // A new event wins over a same-cycle acknowledge so it is never lost.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) pend <= 1'b0;
    else        pend <= set | (pend & ~clr);
  end

`ifdef INTC_OVERRUN_EN
  // Overrun: an event arrives while the previous one is still pending and
  // is not being consumed this cycle. Clear has priority over set.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                    ovf <= 1'b0;
    else if (ovf_clr)              ovf <= 1'b0;
    else if (set & pend & ~clr)    ovf <= 1'b1;
  end
`else
  assign ovf = 1'b0;
  logic unused_ovf_clr;
  assign unused_ovf_clr = ovf_clr;
`endif

endmodule

module interrupt_controller #(
  parameter logic [9:0] VEC_BASE = 10'h3F0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] src,
  input  logic       mask_we,
  input  logic [3:0] mask_in,
  input  logic       int_ack,
  input  logic       eoi,
  input  logic       ovf_clr,
  output logic       int_req,
  output logic [9:0] int_addr,
  output logic       in_service,
  output logic [3:0] pend,
  output logic [3:0] ovf
);

  localparam int NUM_SRC = 4;

  typedef enum logic [1:0] {IDLE, REQ, SERVE} state_t;

  state_t             state;
  logic [1:0]         cur_id;
  logic [NUM_SRC-1:0] mask;
  logic [NUM_SRC-1:0] ack_clr;
  logic [NUM_SRC-1:0] req_vec;
  logic [1:0]         win_id;
  logic               win_vld;

  // Enable mask; a write is seen by arbitration from the following cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)       mask <= '0;
    else if (mask_we) mask <= mask_in;
  end

  // Acknowledge consumes the pending bit of the request being served.
  assign ack_clr = (state == REQ && int_ack) ? (NUM_SRC'(1) << cur_id) : '0;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_lane
    intc_lane u_lane (
      .clock   (clock),
      .reset   (reset),
      .set     (src[i]),
      .clr     (ack_clr[i]),
      .ovf_clr (ovf_clr),
      .pend    (pend[i]),
      .ovf     (ovf[i])
    );
  end

  // Lowest enabled pending index wins; scanning downward leaves the lowest.
  always_comb begin
    req_vec = pend & mask;
    win_vld = |req_vec;
    win_id  = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--)
      if (req_vec[i]) win_id = 2'(i);
  end

  // Request/service FSM. Outputs are registered; the mask is only consulted
  // in IDLE so a raised request is never withdrawn.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cur_id     <= '0;
      int_req    <= 1'b0;
      in_service <= 1'b0;
      int_addr   <= VEC_BASE;
    end else begin
      case (state)
        IDLE: if (win_vld) begin
          state    <= REQ;
          cur_id   <= win_id;
          int_req  <= 1'b1;
          int_addr <= VEC_BASE + {7'b0, win_id, 1'b0};
        end
        REQ: if (int_ack) begin
          state      <= SERVE;
          int_req    <= 1'b0;
          in_service <= 1'b1;
        end
        SERVE: if (eoi) begin
          state      <= IDLE;
          in_service <= 1'b0;
        end
        default: begin
          state      <= IDLE;
          int_req    <= 1'b0;
          in_service <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_interrupt_controller.sv
module tb_interrupt_controller;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] src = '0;
  logic       mask_we = 1'b0;
  logic [3:0] mask_in = '0;
  logic       int_ack = 1'b0;
  logic       eoi = 1'b0;
  logic       ovf_clr = 1'b0;
  logic       int_req;
  logic [9:0] int_addr;
  logic       in_service;
  logic [3:0] pend;
  logic [3:0] ovf;

  localparam logic [3:0] OVF_EXP =
`ifdef INTC_OVERRUN_EN
    4'b0001;
`else
    4'b0000;
`endif

  interrupt_controller #(.VEC_BASE(10'h3F0)) dut (
    .clock      (clock),
    .reset      (reset),
    .src        (src),
    .mask_we    (mask_we),
    .mask_in    (mask_in),
    .int_ack    (int_ack),
    .eoi        (eoi),
    .ovf_clr    (ovf_clr),
    .int_req    (int_req),
    .int_addr   (int_addr),
    .in_service (in_service),
    .pend       (pend),
    .ovf        (ovf)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [9:0] addr;
    int         cyc;
  } exp_t;
  exp_t expq[$];

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [9:0] act, input logic [9:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Expect a request edge d cycles after the current one.
  task automatic expect_req(input logic [9:0] a, input int d);
    exp_t e;
    e.addr = a;
    e.cyc  = cyc + d;
    expq.push_back(e);
  endtask

  task automatic set_mask(input logic [3:0] m);
    mask_we = 1'b1;
    mask_in = m;
    tick();
    mask_we = 1'b0;
  endtask

  task automatic ack_eoi();
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
    eoi = 1'b1;
    tick();
    eoi = 1'b0;
  endtask

  // Monitor: every rising int_req is matched against the scoreboard.
  logic req_q = 1'b0;
  exp_t mon_e;
  always @(negedge clock) begin
    if (int_req && !req_q) begin
      if (expq.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_req: got addr %h at cycle %0d want no request", int_addr, cyc);
      end else begin
        mon_e = expq.pop_front();
        chk("req_addr", int_addr, mon_e.addr);
        n_chk++;
        if (cyc == mon_e.cyc) n_pass++;
        else $display("FAIL req_latency: got cycle %0d want cycle %0d", cyc, mon_e.cyc);
      end
    end
    req_q = int_req;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, want finish before 200000");
    $fatal(1);
  end

  initial begin
    // Reset state
    #1 reset = 1'b0;
    #1;
    chk("rst_int_req",    10'(int_req),    10'h0);
    chk("rst_int_addr",   int_addr,        10'h3F0);
    chk("rst_in_service", 10'(in_service), 10'h0);
    chk("rst_pend",       10'(pend),       10'h0);
    chk("rst_ovf",        10'(ovf),        10'h0);
    tick(2);
    reset = 1'b1;
    tick(2);

    // Timer tick, two-cycle latency
    set_mask(4'b0001);
    tick(2);
    src = 4'b0001;
    expect_req(10'h3F0, 2);
    tick();
    src = '0;
    chk("t0_pend", 10'(pend), 10'h1);
    tick();
    chk("t0_int_req", 10'(int_req), 10'h1);
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
    chk("t0_in_service", 10'(in_service), 10'h1);
    chk("t0_req_drop",   10'(int_req),    10'h0);
    chk("t0_pend_clr",   10'(pend),       10'h0);
    eoi = 1'b1;
    tick();
    eoi = 1'b0;
    chk("t0_eoi", 10'(in_service), 10'h0);
    // Stray ack while idle is ignored
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
    chk("idle_ack_ignored", 10'(in_service), 10'h0);

    // Priority: ids 1 and 3 together, id 1 first, then id 3
    set_mask(4'b1111);
    src = 4'b1010;
    expect_req(10'h3F2, 2);
    tick();
    src = '0;
    chk("prio_pend", 10'(pend), 10'hA);
    tick();
    chk("prio_addr1", int_addr, 10'h3F2);
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
    chk("prio_pend_after_ack", 10'(pend), 10'h8);
    eoi = 1'b1;
    expect_req(10'h3F6, 2);
    tick();
    eoi = 1'b0;
    tick();
    chk("prio_addr3", int_addr, 10'h3F6);
    ack_eoi();
    chk("prio_pend_empty", 10'(pend), 10'h0);

    // Masked source pends silently, unmasking raises it two cycles later
    set_mask(4'b0000);
    src = 4'b0100;
    tick();
    src = '0;
    chk("masked_pend", 10'(pend), 10'h4);
    tick(3);
    chk("masked_no_req", 10'(int_req), 10'h0);
    mask_we = 1'b1;
    mask_in = 4'b0100;
    expect_req(10'h3F4, 2);
    tick();
    mask_we = 1'b0;
    tick();
    chk("unmask_req", 10'(int_req), 10'h1);
    // Masking while requesting does not retract the request
    set_mask(4'b0000);
    tick(2);
    chk("no_retract_req",  10'(int_req), 10'h1);
    chk("no_retract_addr", int_addr,     10'h3F4);
    ack_eoi();
    set_mask(4'b1111);

    // Ack and re-trigger of the same source in one cycle: set wins
    src = 4'b0001;
    expect_req(10'h3F0, 2);
    tick();
    src = '0;
    tick();
    int_ack = 1'b1;
    src = 4'b0001;
    tick();
    int_ack = 1'b0;
    src = '0;
    chk("ackset_serve", 10'(in_service), 10'h1);
    chk("ackset_pend",  10'(pend),       10'h1);
    chk("ackset_ovf",   10'(ovf),        10'h0);
    eoi = 1'b1;
    expect_req(10'h3F0, 2);
    tick();
    eoi = 1'b0;
    tick();
    chk("ackset_rereq", 10'(int_req), 10'h1);
    ack_eoi();

    // Overrun: two pulses without ack
    src = 4'b0001;
    expect_req(10'h3F0, 2);
    tick();
    src = '0;
    tick();
    src = 4'b0001;
    tick();
    src = '0;
    chk("ovf_set", 10'(ovf), 10'(OVF_EXP));
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("ovf_clr", 10'(ovf), 10'h0);
    ack_eoi();
    chk("ovf_pend_empty", 10'(pend), 10'h0);

    // Asynchronous reset while in SERVE
    src = 4'b0010;
    expect_req(10'h3F2, 2);
    tick();
    src = '0;
    tick();
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
    chk("arst_pre_serve", 10'(in_service), 10'h1);
    #2 reset = 1'b0;
    #1;
    chk("arst_in_service", 10'(in_service), 10'h0);
    chk("arst_int_req",    10'(int_req),    10'h0);
    chk("arst_int_addr",   int_addr,        10'h3F0);
    #3 reset = 1'b1;
    tick(3);
    chk("arst_idle_req", 10'(int_req),    10'h0);
    chk("arst_idle_svc", 10'(in_service), 10'h0);
    set_mask(4'b1000);
    tick(2);
    chk("arst_no_event_req", 10'(int_req), 10'h0);
    src = 4'b1000;
    expect_req(10'h3F6, 2);
    tick();
    src = '0;
    tick();
    chk("arst_new_req", 10'(int_req), 10'h1);
    ack_eoi();

    tick(3);
    n_chk++;
    if (expq.size() == 0) n_pass++;
    else $display("FAIL missing_req: got %0d outstanding requests want 0", expq.size());

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
